// File: rtl/vending_ctrl_param.sv
// ---------------------------------------------------------------------------
// vending_ctrl_param
//   Parametrised vending-machine controller. Accepts 5- and 10-unit coins
//   (credit is held in nickels), sells NUM_ITEMS products with individual
//   prices and stock counters, and returns change one coin per cycle,
//   largest coin first.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   coin5      in   pulse: a 5 coin was inserted
//   coin10     in   pulse: a 10 coin was inserted
//   sel        in   product select, bit i = product i
//   cancel     in   abort the transaction and refund all credit
//   restock    in   reload every stock counter to STOCK_INIT
//   available  out  bit i high when product i can be bought right now
//   drop       out  pulse: dispense product i (one-hot or zero)
//   change5    out  pulse: return a 5 coin
//   change10   out  pulse: return a 10 coin
//   reject     out  pulse: coin sampled on the previous edge was refused
//   credit     out  current credit in nickels
//   busy       out  high while dispensing or returning change
// ---------------------------------------------------------------------------
module vending_ctrl_param #(
  parameter int                      NUM_ITEMS  = 3,
  parameter int                      CW         = 8,
  parameter logic [NUM_ITEMS*CW-1:0] PRICES     = {8'd4, 8'd3, 8'd2},
  parameter int                      MAX_CREDIT = 10,
  parameter int                      SW         = 4,
  parameter int                      STOCK_INIT = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 coin5,
  input  logic                 coin10,
  input  logic [NUM_ITEMS-1:0] sel,
  input  logic                 cancel,
  input  logic                 restock,
  output logic [NUM_ITEMS-1:0] available,
  output logic [NUM_ITEMS-1:0] drop,
  output logic                 change5,
  output logic                 change10,
  output logic                 reject,
  output logic [CW-1:0]        credit,
  output logic                 busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DROP   = 2'd1,
    S_CHANGE = 2'd2
  } state_e;

  localparam logic [CW-1:0]   ONE_C      = CW'(1);
  localparam logic [CW-1:0]   TWO_C      = CW'(2);
  localparam logic [CW+1:0]   MAX_C      = (CW+2)'(MAX_CREDIT);
  localparam logic [SW-1:0]   STOCK_RST  = SW'(STOCK_INIT);
  localparam logic [SW-1:0]   STOCK_ONE  = SW'(1);

  state_e                          state_q,  state_d;
  logic [CW-1:0]                   credit_q, credit_d;
  logic [NUM_ITEMS-1:0][SW-1:0]    stock_q,  stock_d;
  logic [NUM_ITEMS-1:0]            drop_q,   drop_d;
  logic                            reject_q, reject_d;

  logic [NUM_ITEMS-1:0][CW-1:0]    price;
  logic [NUM_ITEMS-1:0]            avail;
  logic [NUM_ITEMS-1:0]            valid_sel;
  logic [NUM_ITEMS-1:0]            win;
  logic [CW-1:0]                   price_win;
  logic [CW+1:0]                   coin_sum;
  logic                            coin_any;

  // Per-item price slice and purchasability, decoded from registered state.
  generate
    for (genvar gi = 0; gi < NUM_ITEMS; gi++) begin : g_item
      assign price[gi] = PRICES[gi*CW +: CW];
      assign avail[gi] = (state_q == S_IDLE) && (credit_q >= price[gi]) &&
                         (stock_q[gi] != '0);
    end
  endgenerate

  // Lowest requested-and-available item wins: isolate the lowest set bit.
  assign valid_sel = sel & avail;
  assign win       = valid_sel & (~valid_sel + NUM_ITEMS'(1));

  always_comb begin
    price_win = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (win[i]) price_win = price_win | price[i];
    end
  end

  // Coin value in nickels is simply {coin10, coin5}; extra headroom bits
  // keep the overflow test from wrapping.
  assign coin_any = coin5 | coin10;
  assign coin_sum = {2'b00, credit_q} + {{CW{1'b0}}, coin10, coin5};

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    stock_d  = stock_q;
    drop_d   = '0;
    reject_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cancel) begin
          // Cancel consumes the cycle; any coin alongside it is refused.
          reject_d = coin_any;
          if (credit_q != '0) state_d = S_CHANGE;
        end else if (win != '0) begin
          reject_d = coin_any;
          credit_d = credit_q - price_win;
          drop_d   = win;
          state_d  = S_DROP;
          for (int i = 0; i < NUM_ITEMS; i++) begin
            if (win[i]) stock_d[i] = stock_q[i] - STOCK_ONE;
          end
        end else if (coin_any) begin
          // All-or-nothing: a coin pair that would overflow is refused whole.
          if (coin_sum <= MAX_C) credit_d = coin_sum[CW-1:0];
          else                   reject_d = 1'b1;
        end
      end

      S_DROP: begin
        reject_d = coin_any;
        state_d  = (credit_q != '0) ? S_CHANGE : S_IDLE;
      end

      S_CHANGE: begin
        reject_d = coin_any;
        if (credit_q >= TWO_C) credit_d = credit_q - TWO_C;
        else                   credit_d = '0;
        state_d = (credit_d == '0) ? S_IDLE : S_CHANGE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Restock wins over a same-cycle purchase decrement.
    if (restock) begin
      for (int i = 0; i < NUM_ITEMS; i++) stock_d[i] = STOCK_RST;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      credit_q <= '0;
      drop_q   <= '0;
      reject_q <= 1'b0;
      for (int i = 0; i < NUM_ITEMS; i++) stock_q[i] <= STOCK_RST;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      stock_q  <= stock_d;
      drop_q   <= drop_d;
      reject_q <= reject_d;
    end
  end

  // Change coins are presented while in CHANGE; the matching credit
  // decrement happens on the edge that ends the cycle.
  assign change10  = (state_q == S_CHANGE) && (credit_q >= TWO_C);
  assign change5   = (state_q == S_CHANGE) && (credit_q == ONE_C);
  assign busy      = (state_q != S_IDLE);
  assign available = avail;
  assign drop      = drop_q;
  assign reject    = reject_q;
  assign credit    = credit_q;

endmodule

// File: tb/tb_vending_ctrl_param.sv
module tb_vending_ctrl_param;

  logic       clk;
  logic       rst_n;
  logic       coin5;
  logic       coin10;
  logic [2:0] sel;
  logic       cancel;
  logic       restock;
  logic [2:0] available;
  logic [2:0] drop;
  logic       change5;
  logic       change10;
  logic       reject;
  logic [7:0] credit;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  vending_ctrl_param dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .coin5     (coin5),
    .coin10    (coin10),
    .sel       (sel),
    .cancel    (cancel),
    .restock   (restock),
    .available (available),
    .drop      (drop),
    .change5   (change5),
    .change10  (change10),
    .reject    (reject),
    .credit    (credit),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One clock transaction: drive inputs, take the edge, sample 1 ns later.
  task automatic cyc(input logic c5, input logic c10, input logic [2:0] s,
                     input logic can, input logic rs);
    coin5   = c5;
    coin10  = c10;
    sel     = s;
    cancel  = can;
    restock = rs;
    @(posedge clk);
    #1;
    coin5   = 1'b0;
    coin10  = 1'b0;
    sel     = 3'b000;
    cancel  = 1'b0;
    restock = 1'b0;
    $display("[TB] t=%0t in c5=%b c10=%b sel=%b can=%b rs=%b -> credit=%0d avail=%b drop=%b ch5=%b ch10=%b rej=%b busy=%b",
             $time, c5, c10, s, can, rs, credit, available, drop, change5, change10, reject, busy);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
  endtask

  task automatic c10();
    cyc(1'b0, 1'b1, 3'b000, 1'b0, 1'b0);
  endtask

  task automatic c5();
    cyc(1'b1, 1'b0, 3'b000, 1'b0, 1'b0);
  endtask

  // Cancel and wait (bounded) for the refund to finish.
  task automatic drain(input string tag);
    cyc(1'b0, 1'b0, 3'b000, 1'b1, 1'b0);
    for (int k = 0; k < 20 && busy; k++) idle();
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_credit"}, credit, 0);
  endtask

  initial begin
    coin5 = 0; coin10 = 0; sel = 0; cancel = 0; restock = 0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_eq("rst_credit", credit, 0);
    check_eq("rst_avail", available, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_drop", drop, 0);
    check_eq("rst_change", {change10, change5, reject}, 0);

    // 1: 10+10+5, buy coffee (price 4), one 5 back.
    c10(); c10(); c5();
    check_eq("t1_credit", credit, 5);
    check_eq("t1_avail", available, 3'b111);
    cyc(1'b0, 1'b0, 3'b100, 1'b0, 1'b0);
    check_eq("t1_drop", drop, 3'b100);
    check_eq("t1_credit_after_sel", credit, 1);
    check_eq("t1_busy_drop", busy, 1);
    idle();
    check_eq("t1_drop_gone", drop, 0);
    check_eq("t1_change5", change5, 1);
    check_eq("t1_change10", change10, 0);
    idle();
    check_eq("t1_credit_end", credit, 0);
    check_eq("t1_avail_end", available, 3'b000);
    check_eq("t1_busy_end", busy, 0);
    check_eq("t1_change5_end", change5, 0);

    // 2: 10 then cancel -> single change10; coin during CHANGE is refused.
    c10();
    check_eq("t2_credit", credit, 2);
    cyc(1'b0, 1'b0, 3'b000, 1'b1, 1'b0);
    check_eq("t2_change10", change10, 1);
    check_eq("t2_drop", drop, 0);
    cyc(1'b1, 1'b0, 3'b000, 1'b0, 1'b0);
    check_eq("t2_reject_in_change", reject, 1);
    check_eq("t2_one_pulse", change10, 0);
    check_eq("t2_busy", busy, 0);
    check_eq("t2_credit_end", credit, 0);

    // 3: exhaust water stock, then restock.
    for (int n = 0; n < 2; n++) begin
      c10();
      cyc(1'b0, 1'b0, 3'b001, 1'b0, 1'b0);
      check_eq("t3_buy_water", drop, 3'b001);
      idle();
    end
    c10();
    check_eq("t3_sold_out", available, 3'b000);
    cyc(1'b0, 1'b0, 3'b001, 1'b0, 1'b0);
    check_eq("t3_ignored_drop", drop, 0);
    check_eq("t3_ignored_credit", credit, 2);
    check_eq("t3_ignored_busy", busy, 0);
    cyc(1'b0, 1'b0, 3'b000, 1'b0, 1'b1);
    check_eq("t3_restocked", available, 3'b001);
    drain("t3_drain");

    // 4: credit ceiling.
    for (int n = 0; n < 5; n++) c10();
    check_eq("t4_credit_max", credit, 10);
    c5();
    check_eq("t4_reject", reject, 1);
    check_eq("t4_credit_kept", credit, 10);
    idle();
    check_eq("t4_reject_pulse", reject, 0);
    drain("t4_drain1");
    for (int n = 0; n < 4; n++) c10();
    check_eq("t4_credit8", credit, 8);
    cyc(1'b1, 1'b1, 3'b000, 1'b0, 1'b0);
    check_eq("t4_both_reject", reject, 1);
    check_eq("t4_both_credit", credit, 8);
    drain("t4_drain2");

    // 5: credit 3, sel 011 -> water wins, then a 5 back.
    c10(); c5();
    check_eq("t5_avail", available, 3'b011);
    cyc(1'b0, 1'b0, 3'b011, 1'b0, 1'b0);
    check_eq("t5_drop", drop, 3'b001);
    check_eq("t5_credit", credit, 1);
    idle();
    check_eq("t5_change5", change5, 1);
    idle();
    check_eq("t5_idle", busy, 0);
    c10();
    cyc(1'b0, 1'b0, 3'b001, 1'b1, 1'b0);
    check_eq("t5_cancel_wins_drop", drop, 0);
    check_eq("t5_cancel_wins_ch10", change10, 1);
    idle();
    check_eq("t5_cancel_done", {busy, credit}, 0);

    // 6: reset in the middle of change.
    c10(); c10();
    cyc(1'b0, 1'b0, 3'b000, 1'b1, 1'b0);
    check_eq("t6_first_ch10", change10, 1);
    idle();
    check_eq("t6_credit_mid", credit, 2);
    rst_n = 1'b0;
    idle();
    rst_n = 1'b1;
    check_eq("t6_credit", credit, 0);
    check_eq("t6_busy", busy, 0);
    check_eq("t6_outs", {drop, change10, change5, reject}, 0);
    check_eq("t6_avail", available, 0);
    // Water stock was 1 before reset; two purchases work only if reset reloaded it.
    c10();
    cyc(1'b0, 1'b0, 3'b001, 1'b0, 1'b0);
    check_eq("t6_buy1", drop, 3'b001);
    idle();
    c10();
    check_eq("t6_stock_reloaded", available, 3'b001);
    drain("t6_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
